au_dispatch: RTL and testbench

Command front-end for the 8-bit arithmetic unit (add/sub/Booth multiply/SRT divide).
- Accepts opcode+operand commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one AU operation at a time: drives operands and the correct start level, waits for done, captures result and flags.
- Returns a response over a second valid/ready interface.
- Also provides divide-by-zero screening and a watchdog timeout with AU flush.

---
 rtl/au_dispatch.sv | 210 +++++++++++++++++++++
 tb/tb_au_dispatch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_dispatch.sv
// ---------------------------------------------------------------------------
// au_dispatch
//   Command front-end for the 8-bit arithmetic unit (add/sub/Booth mul/SRT div).
//   Commands are queued in a small FIFO and issued to the AU one at a time.
//   The start level is held with stable operands until au_done. The
//   result and flags are then returned on a valid/ready response port.
//   A divide by zero is answered without touching the AU. An operation
//   that never completes is aborted after TIMEOUT_CYCLES, and the AU is
//   flushed with a one-cycle pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b     opcode (00 add, 01 sub, 10 mul, 11 div), operands
//   au_a, au_b               operands to the AU (registered)
//   au_start{add,sub,mul,div} registered start levels, at most one high
//   au_flush                 one-cycle AU reset pulse after a timeout
//   au_result, au_done       AU result and completion
//   au_{overflow,negative,zero,carry}  AU add/sub flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_op, rsp_result       opcode and result of the completed command
//   rsp_flags                {overflow, negative, zero, carry}
//   rsp_err                  00 ok, 01 divide-by-zero, 10 timeout
//   fifo_count               current FIFO occupancy
// ---------------------------------------------------------------------------
module au_dispatch #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  output logic [7:0]               au_a,
  output logic [7:0]               au_b,
  output logic                     au_startadd,
  output logic                     au_startsub,
  output logic                     au_startmul,
  output logic                     au_startdiv,
  output logic                     au_flush,
  input  logic [15:0]              au_result,
  input  logic                     au_done,
  input  logic                     au_overflow,
  input  logic                     au_negative,
  input  logic                     au_zero,
  input  logic                     au_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_op,
  output logic [15:0]              rsp_result,
  output logic [3:0]               rsp_flags,
  output logic [1:0]               rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_DIV      = 2'b11;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // One-hot start vector {div, mul, sub, add}, indexed by opcode.
  function automatic logic [3:0] op_to_start(input logic [1:0] op);
    op_to_start = 4'b0001 << op;
  endfunction

  // Add/sub report the AU's own flags; mul/div derive sign and zero
  // from the 16-bit result and never report overflow or carry.
  function automatic logic [3:0] pack_flags(
    input logic [1:0]         op,
    input logic signed [15:0] result,
    input logic               ovf,
    input logic               neg,
    input logic               zro,
    input logic               cry
  );
    if (!op[1]) pack_flags = {ovf, neg, zro, cry};
    else        pack_flags = {1'b0, (result < 0), (result == 16'sd0), 1'b0};
  endfunction

  // Command FIFO
  logic [1:0]       fifo_op [DEPTH];
  logic [7:0]       fifo_a  [DEPTH];
  logic [7:0]       fifo_b  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             push, pop;
  logic [1:0]       head_op;
  logic [7:0]       head_a, head_b;
  logic             head_div0;

  logic [3:0]       start_q;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit;

  assign cmd_ready  = (count != CNT_W'(DEPTH));
  assign fifo_count = count;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);

  assign head_op    = fifo_op[rd_ptr];
  assign head_a     = fifo_a[rd_ptr];
  assign head_b     = fifo_b[rd_ptr];
  assign head_div0  = (head_op == OP_DIV) && (head_b == 8'h00);

  assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  assign {au_startdiv, au_startmul, au_startsub, au_startadd} = start_q;
  assign rsp_valid  = (state == RESP);

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_op;
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop) state_nxt = head_div0 ? RESP : ISSUE;
      ISSUE:   if (au_done || to_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue / capture stage: AU drive and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      au_a       <= '0;
      au_b       <= '0;
      start_q    <= '0;
      au_flush   <= 1'b0;
      to_cnt     <= '0;
      rsp_op     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      au_flush <= 1'b0;
      if (pop) begin
        au_a   <= head_a;
        au_b   <= head_b;
        rsp_op <= head_op;
        to_cnt <= '0;
        if (head_div0) begin
          rsp_result <= 16'hFFFF;
          rsp_flags  <= '0;
          rsp_err    <= ERR_DIV0;
        end else begin
          start_q <= op_to_start(head_op);
        end
      end else if (state == ISSUE) begin
        if (au_done) begin
          start_q    <= '0;
          rsp_result <= au_result;
          rsp_flags  <= pack_flags(rsp_op, au_result, au_overflow,
                                   au_negative, au_zero, au_carry);
          rsp_err    <= ERR_OK;
        end else if (to_hit) begin
          start_q    <= '0;
          au_flush   <= 1'b1;
          rsp_result <= '0;
          rsp_flags  <= '0;
          rsp_err    <= ERR_TIMEOUT;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_au_dispatch.sv
module tb_au_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  au_a, au_b;
  logic        au_startadd, au_startsub, au_startmul, au_startdiv, au_flush;
  logic [15:0] au_result;
  logic        au_done, au_overflow, au_negative, au_zero, au_carry;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_op;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [1:0]  rsp_err;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  au_dispatch #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .au_a(au_a), .au_b(au_b),
    .au_startadd(au_startadd), .au_startsub(au_startsub),
    .au_startmul(au_startmul), .au_startdiv(au_startdiv),
    .au_flush(au_flush), .au_result(au_result), .au_done(au_done),
    .au_overflow(au_overflow), .au_negative(au_negative),
    .au_zero(au_zero), .au_carry(au_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
  } au_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [1:0]  err;
  } rsp_t;

  // Behavioural AU: add/sub sign-extended 8-bit, signed product, {quotient, remainder}.
  function automatic au_t au_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    au_t r;
    logic [8:0] s;
    int p;
    r = '0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = {{8{s[7]}}, s[7:0]};
        r.fl = {(a[7] == b[7]) && (s[7] != a[7]), s[7], (s[7:0] == 8'h00), s[8]};
      end
      2'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r.res = {{8{s[7]}}, s[7:0]};
        r.fl = {(a[7] != b[7]) && (s[7] != a[7]), s[7], (s[7:0] == 8'h00), (a >= b)};
      end
      2'd2: begin
        p = $signed(a) * $signed(b);
        r.res = 16'(p);
      end
      default: begin
        if (b != 0) r.res = {8'(a / b), 8'(a % b)};
      end
    endcase
    return r;
  endfunction

  // Expected response of the dispatcher for one command.
  function automatic rsp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input bit hang);
    rsp_t e;
    au_t  u;
    e.op = op;
    if (op == 2'd3 && b == 8'h00) begin
      e.res = 16'hFFFF; e.fl = 4'h0; e.err = 2'b01;
    end else if (hang && op[1]) begin
      e.res = 16'h0000; e.fl = 4'h0; e.err = 2'b10;
    end else begin
      u = au_ref(op, a, b);
      e.res = u.res;
      e.err = 2'b00;
      if (op[1]) e.fl = {1'b0, u.res[15], (u.res == 16'h0000), 1'b0};
      else       e.fl = u.fl;
    end
    return e;
  endfunction

  // AU stub: add/sub complete one cycle after start, mul/div after stub_lat_md
  // cycles, or never when stub_hang is set.
  int   stub_lat_md = 3;
  bit   stub_hang   = 0;
  int   stub_cnt;
  logic [1:0] stub_op;
  logic [3:0] starts;
  au_t  au_o;

  assign starts = {au_startdiv, au_startmul, au_startsub, au_startadd};

  always_comb begin
    stub_op = 2'd0;
    if (au_startdiv)      stub_op = 2'd3;
    else if (au_startmul) stub_op = 2'd2;
    else if (au_startsub) stub_op = 2'd1;
    au_o = au_ref(stub_op, au_a, au_b);
  end

  assign au_result = au_o.res;
  assign {au_overflow, au_negative, au_zero, au_carry} = au_o.fl;

  always @(posedge clk or posedge rst) begin
    if (rst || au_flush || starts == 4'h0) begin
      stub_cnt <= 0;
      au_done  <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (au_startmul || au_startdiv) au_done <= !stub_hang && (stub_cnt + 1 >= stub_lat_md);
      else                            au_done <= 1'b1;
    end
  end

  // Activity monitor sampled on the falling edge.
  int   start_hi_cycles = 0, flush_cycles = 0, start_rises = 0, spacing_viol = 0;
  logic [3:0] prev_starts = 4'h0;
  always @(negedge clk) begin
    if (!rst) begin
      if (starts != 4'h0) start_hi_cycles++;
      if (au_flush) flush_cycles++;
      if (starts != 4'h0 && prev_starts == 4'h0) start_rises++;
      if ($countones(starts) > 1) spacing_viol++;
      if (starts != 4'h0 && prev_starts != 4'h0 && starts != prev_starts) spacing_viol++;
      if (starts != 4'h0 && rsp_valid) spacing_viol++;
    end
    prev_starts = rst ? 4'h0 : starts;
  end

  int   n_checks = 0, n_fail = 0;
  rsp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    exp_q.push_back(model(op, a, b, stub_hang));
  endtask

  // Wait for a response, compare against the model, optionally stall for
  // 'hold' cycles checking stability and AU quiescence, then accept it.
  task automatic drain_one(input int hold);
    rsp_t e;
    int t;
    e = '0;
    chk("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    @(negedge clk);
    t = 0;
    while (!rsp_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    chk("rsp_op", 32'(rsp_op), 32'(e.op));
    chk("rsp_result", 32'(rsp_result), 32'(e.res));
    chk("rsp_flags", 32'(rsp_flags), 32'(e.fl));
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp", {rsp_valid, 5'd0, rsp_op, rsp_result, rsp_flags, rsp_err, 2'd0},
          {1'b1, 5'd0, e.op, e.res, e.fl, e.err, 2'd0});
      chk("hold_no_start", 32'(starts), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready_count"}, {cmd_ready, 28'd0, fifo_count}, {1'b1, 31'd0});
    chk({tag, "_au"}, {starts, au_flush, 3'd0, au_a, au_b}, 32'd0);
    chk({tag, "_rsp"}, {rsp_valid, 5'd0, rsp_op, rsp_result, rsp_flags, rsp_err, 2'd0}, 32'd0);
  endtask

  initial begin
    int lat, k, snap, snap2;
    logic [1:0] rop;
    logic [7:0] ra, rb;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 8'h00; cmd_b = 8'h00; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // add with latency measurement from the push edge
    push(2'd0, 8'h30, 8'h12);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk("add_latency", 32'(lat), 32'd3);
    drain_one(0);

    push(2'd0, 8'h7F, 8'h01);
    drain_one(0);

    // sub with a 10-cycle consumer stall while another command waits
    push(2'd1, 8'h80, 8'h80);
    push(2'd1, 8'h30, 8'h50);
    drain_one(10);
    drain_one(0);

    // back-to-back pipeline until the FIFO fills
    stub_lat_md = 3;
    push(2'd2, 8'h10, 8'h10);
    push(2'd2, 8'hF0, 8'h10);
    push(2'd3, 8'h40, 8'h08);
    push(2'd3, 8'h43, 8'h08);
    push(2'd0, 8'h01, 8'h02);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 8'h55; cmd_b = 8'h11;
    repeat (3) @(negedge clk);
    chk("full_stall", {cmd_ready, 28'd0, fifo_count}, 32'd4);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) drain_one(0);

    // divide by zero bypasses the AU; the next command runs normally
    snap = start_rises;
    push(2'd3, 8'h25, 8'h00);
    push(2'd0, 8'h03, 8'h04);
    drain_one(0);
    chk("div0_no_start", 32'(start_rises - snap), 32'd0);
    drain_one(0);

    // watchdog: mul never completes
    stub_hang = 1;
    snap  = start_hi_cycles;
    snap2 = flush_cycles;
    push(2'd2, 8'h12, 8'h34);
    drain_one(0);
    repeat (2) @(negedge clk);
    chk("timeout_start_cycles", 32'(start_hi_cycles - snap), 32'd64);
    chk("timeout_flush_cycles", 32'(flush_cycles - snap2), 32'd1);
    stub_hang = 0;

    // randomized bursts against the model
    for (int r = 0; r < 6; r++) begin
      stub_lat_md = $urandom_range(1, 6);
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        rop = 2'($urandom_range(0, 3));
        ra  = 8'($urandom);
        rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        push(rop, ra, rb);
      end
      for (int i = 0; i < k; i++) drain_one($urandom_range(0, 3));
    end

    // reset in the middle of an ISSUE with queued work
    stub_lat_md = 20;
    push(2'd2, 8'h07, 8'h09);
    push(2'd0, 8'h01, 8'h01);
    push(2'd0, 8'h02, 8'h02);
    k = 0;
    while (!au_startmul && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mid_issue_reached", 32'(au_startmul), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    stub_lat_md = 3;
    push(2'd3, 8'h43, 8'h08);
    drain_one(0);

    chk("start_spacing", 32'(spacing_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
